// File: rtl/meter_pkg.sv
// Shared types and constants for the parking-meter slice timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package meter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    EXPIRE = 2'd2
  } state_t;

  localparam int BCD_W       = 4;
  localparam int SLICE_S_DEF = 30;
  localparam int FAST_SIM_P  = 4;

  typedef logic [2*BCD_W-1:0] bcd2_t;

  // Two-digit BCD of a value 0..99, tens digit in the upper nibble.
  function automatic bcd2_t bin2bcd(input int v);
    return {BCD_W'(v / 10), BCD_W'(v % 10)};
  endfunction

endpackage

// File: rtl/meter_slice_timer_if.sv
// Handshake bundle between the meter FSM (master) and the slice timer (slave).
// Latency: n/a (wires only).
// Backpressure: none; ct is a level request, t a single-cycle pulse.
interface meter_slice_timer_if;
  import meter_pkg::*;

  logic             ct;
  logic             t;
  logic [BCD_W-1:0] sec_tens;
  logic [BCD_W-1:0] sec_ones;
  logic             running;
  logic             tick;

  modport master (output ct, input t, sec_tens, sec_ones, running, tick);
  modport slave  (input ct, output t, sec_tens, sec_ones, running, tick);
endinterface

// File: rtl/bcd_down_counter2.sv
// Two-digit BCD down-counter with load, enable, zero and one-remaining detect.
// Latency: load/decrement visible one cycle after the enabling edge.
// Backpressure: none; load beats enable, counting stops at 00.
module bcd_down_counter2
  import meter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BCD_W-1:0] load_tens,
  input  logic [BCD_W-1:0] load_ones,
  input  logic             en,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             zero,
  output logic             last
);

  assign zero = (tens == '0) && (ones == '0);
  // Count is 01: the next enabled decrement lands on zero.
  assign last = (tens == '0) && (ones == BCD_W'(1));

  // Load or decrement; ones digit 0 borrows from tens and wraps to 9.
  always_ff @(posedge clk) begin
    if (rst) begin
      tens <= '0;
      ones <= '0;
    end else if (load) begin
      tens <= load_tens;
      ones <= load_ones;
    end else if (en && !zero) begin
      if (ones == '0) begin
        ones <= BCD_W'(9);
        tens <= tens - BCD_W'(1);
      end else begin
        ones <= ones - BCD_W'(1);
      end
    end
  end

endmodule

// File: rtl/meter_slice_timer.sv
// Parking slice timer: one-second prescaler plus BCD seconds countdown; METER_FAST_SIM_EN shortens the second to 4 clks.
// Latency: ct -> reloaded display/running next cycle; t rises SLICE_S*P+1 cycles after ct.
// Backpressure: none; ct always wins over expiry, rst wins over everything.
module meter_slice_timer
  import meter_pkg::*;
#(
  parameter int CLK_HZ  = 100000000,
  parameter int SLICE_S = SLICE_S_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  meter_slice_timer_if.slave   bus
);

`ifdef METER_FAST_SIM_EN
  localparam int P = FAST_SIM_P;
`else
  localparam int P = CLK_HZ;
`endif
  localparam int              PW        = (P > 1) ? $clog2(P) : 1;
  localparam logic [PW-1:0]   P_LAST    = PW'(P - 1);
  localparam bcd2_t           SLICE_BCD = bin2bcd(SLICE_S);

  logic [PW-1:0]    presc;
  logic             tick;
  state_t           state;
  logic             t_q;
  logic             run_q;
  logic [BCD_W-1:0] tens;
  logic [BCD_W-1:0] ones;
  logic             cnt_zero;
  logic             cnt_last;
  logic             cnt_en;

  assign tick = (presc == P_LAST);

  // Free-running prescaler, realigned by every slice load so each slice gets full seconds.
  always_ff @(posedge clk) begin
    if (rst || bus.ct) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // A load cycle never decrements, so a ct coinciding with the final tick just restarts.
  assign cnt_en = (state == RUN) && tick && !bus.ct;

  bcd_down_counter2 u_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (bus.ct),
    .load_tens (SLICE_BCD[2*BCD_W-1:BCD_W]),
    .load_ones (SLICE_BCD[BCD_W-1:0]),
    .en        (cnt_en && !cnt_zero),
    .tens      (tens),
    .ones      (ones),
    .zero      (cnt_zero),
    .last      (cnt_last)
  );

  // Slice FSM with registered Moore outputs t and running.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      t_q   <= 1'b0;
      run_q <= 1'b0;
    end else if (bus.ct) begin
      state <= RUN;
      t_q   <= 1'b0;
      run_q <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (tick && cnt_last) begin
            state <= EXPIRE;
            t_q   <= 1'b1;
            run_q <= 1'b0;
          end
        end
        EXPIRE: begin
          state <= IDLE;
          t_q   <= 1'b0;
          run_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
          t_q   <= 1'b0;
          run_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.t        = t_q;
  assign bus.running  = run_q;
  assign bus.sec_tens = tens;
  assign bus.sec_ones = ones;
  assign bus.tick     = tick;

endmodule

// File: doc/meter_slice_timer.md
METER_SLICE_TIMER -- requirements
Module: meter_slice_timer

Interface
REQ-001 The module SHALL have parameter CLK_HZ, default 100000000, meaning the clk cycles per one-second tick.
REQ-002 The module SHALL have parameter SLICE_S, default 30, meaning the seconds per parking time slice; legal range 1..99.
REQ-003 Port clk  input  1  the single clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port ct  input  1  slice load/restart request from the meter FSM, sampled each clk edge.
REQ-006 Port t  output  1  slice-expired pulse to the meter FSM, one clk cycle wide.
REQ-007 Port sec_tens  output  4  remaining seconds, tens digit, BCD.
REQ-008 Port sec_ones  output  4  remaining seconds, ones digit, BCD.
REQ-009 Port running  output  1  high while a slice is counting.
REQ-010 Port tick  output  1  one-cycle one-second prescaler strobe, for debug and display blink.

Function
REQ-011 The block SHALL implement three states: IDLE, RUN and EXPIRE.
REQ-012 The prescaler SHALL count 0..P-1 and assert tick in the cycle its value equals P-1, then wrap to 0; P = CLK_HZ.
REQ-013 When ct=1 is sampled in any state, the next state SHALL be RUN, with remaining loaded to SLICE_S in BCD and the prescaler cleared to 0.
REQ-014 When ct=1 is sampled, running=1 and sec_tens/sec_ones = SLICE_S SHALL be visible in the following cycle.
REQ-015 In RUN, each tick SHALL decrement remaining by one in BCD: a ones digit of 0 wraps to 9 and the tens digit is decremented.
REQ-016 In RUN, a tick with remaining=01 SHALL load 00 and move the block to EXPIRE.
REQ-017 EXPIRE SHALL assert t=1 for exactly one cycle and then return to IDLE; t is a registered Moore output.
REQ-018 t SHALL rise exactly SLICE_S*P+1 cycles after the cycle in which ct was sampled, provided ct is not sampled again.
REQ-019 If ct and the final tick coincide, ct SHALL win: the slice is reloaded and no EXPIRE or t is produced.
REQ-020 If ct is sampled while in EXPIRE, t SHALL still be 1 in that cycle and the next state SHALL be RUN, reloaded.
REQ-021 In IDLE, the prescaler SHALL keep free-running, remaining SHALL hold its last value (00 after an expiry), and running=0.
REQ-022 running SHALL be 1 only in RUN.
REQ-023 Holding ct high for several cycles SHALL keep reloading the slice each cycle; counting starts the cycle after ct falls.

Reset
REQ-024 With rst=1 sampled, the next state SHALL be IDLE, with prescaler=0, sec_tens=0, sec_ones=0, t=0, running=0 and tick=0.
REQ-025 rst SHALL take priority over ct.
REQ-026 rst asserted mid-slice SHALL abort the slice with no t pulse.

Configuration
REQ-027 With macro METER_FAST_SIM_EN defined, P SHALL be 4 regardless of CLK_HZ, so simulations complete quickly.
REQ-028 Without METER_FAST_SIM_EN defined, P SHALL equal CLK_HZ and the prescaler width SHALL be $clog2(CLK_HZ).

Structure
REQ-029 The shared package meter_pkg SHALL hold:
- the state encoding: IDLE, RUN, EXPIRE;
- the BCD digit width constant (4);
- the default slice length constant (30);
- the fast-sim period constant (4).
REQ-030 The two-digit BCD down-counter with load, enable and zero detect SHALL be a sub-module named bcd_down_counter2.

Verification
All scenarios use METER_FAST_SIM_EN and SLICE_S=30.
REQ-031 Scenario: pulse ct at cycle 10 -> cycle 11 shows 30 and running=1; tens/ones reach 29 at cycle 15; t=1 only at cycle 131; running=0 from cycle 131.
REQ-032 Scenario: BCD wrap -> the display sequence runs 30, 29 ... 20, 19 ... 10, 09 ... 01, 00 with no invalid digit (>9) ever seen.
REQ-033 Scenario: ct at cycle 10, then ct again in the cycle the final tick occurs -> no t at cycle 131; display shows 30 and t fires 121 cycles after the second ct.
REQ-034 Scenario: ct asserted in the EXPIRE cycle -> t=1 in that cycle and running=1 with 30 shown in the next cycle.
REQ-035 Scenario: rst at cycle 60 mid-slice -> from cycle 61, outputs are all zero and IDLE; no t pulse appears for 200 cycles.
REQ-036 Scenario: ct held high for cycles 10..14 -> 30 holds through cycle 15; t fires at cycle 135.
